// File: rtl/msi_pkg.sv
// Shared definitions for the MSI cache cluster.
// Covers the snoop-bus message encoding and the cache line state encoding.
package msi_pkg;

    localparam int MSG_W = 3;

    localparam logic [MSG_W-1:0] BUS_IDLE = 3'd0;
    localparam logic [MSG_W-1:0] BUS_RD   = 3'd1;
    localparam logic [MSG_W-1:0] BUS_RDX  = 3'd2;
    localparam logic [MSG_W-1:0] BUS_UPGR = 3'd3;

    localparam logic [1:0] INVALID  = 2'd0;
    localparam logic [1:0] SHARED   = 2'd1;
    localparam logic [1:0] MODIFIED = 2'd2;

    // Encodings above UPGR carry no meaning on the bus and are folded to IDLE.
    function automatic logic [MSG_W-1:0] bus_msg_clean(input logic [MSG_W-1:0] m);
        return (m > BUS_UPGR) ? BUS_IDLE : m;
    endfunction

endpackage

// File: rtl/msi_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Scans the pending vector starting at ptr_i, wrapping at N, and reports the
// first set bit as a onehot grant plus its index.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         pending_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 valid_o
);

    localparam int IW = $clog2(N);

    // First pending requester at or after the pointer wins.
    always_comb begin
        int j;
        j       = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid_o && pending_i[IW'(j)]) begin
                valid_o         = 1'b1;
                gnt_o[IW'(j)]   = 1'b1;
                idx_o           = IW'(j);
            end
        end
    end

endmodule

// File: rtl/msi_bus_arbiter.sv
// Snoop-bus controller for the MSI cache cluster.
// Latches single-cycle bus requests, grants them round-robin, broadcasts the
// owner's message/address to the other caches, and holds a write-back window
// whenever a snooper flushes.
module msi_bus_arbiter
    import msi_pkg::*;
#(
    parameter int NUM_CPUS     = 2,
    parameter int NUM_LINES    = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CPUS-1:0]           req_i,
    output logic [NUM_CPUS-1:0]           gnt_o,
    input  logic [MSG_W*NUM_CPUS-1:0]     msg_i,
    input  logic [NUM_LINES*NUM_CPUS-1:0] addr_i,
    input  logic [NUM_CPUS-1:0]           flush_i,
    output logic [MSG_W*NUM_CPUS-1:0]     snoop_msg_o,
    output logic [NUM_LINES-1:0]          snoop_addr_o,
    output logic [$clog2(NUM_CPUS)-1:0]   owner_o,
    output logic                          busy_o,
    output logic                          wb_o,
    output logic                          txn_done_o
);

    localparam int IW = $clog2(NUM_CPUS);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_BUS   = 2'd2;
    localparam logic [1:0] ST_WB    = 2'd3;

    logic [1:0]          state_q,      state_d;
    logic [NUM_CPUS-1:0] pending_q,    pending_d;
    logic [IW-1:0]       rr_ptr_q,     rr_ptr_d;
    logic [IW-1:0]       owner_q,      owner_d;
    logic [NUM_CPUS-1:0] owner_mask_q, owner_mask_d;
    logic [CW-1:0]       wb_cnt_q,     wb_cnt_d;

    logic [NUM_CPUS-1:0] arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_valid;

    logic [MSG_W-1:0]     msg_arr  [NUM_CPUS];
    logic [NUM_LINES-1:0] addr_arr [NUM_CPUS];
    logic [MSG_W-1:0]     owner_msg;
    logic                 snoop_flush;

    // A request seen this cycle can win immediately, so the picker looks at
    // the latched requests plus the live ones.
    rr_arbiter #(.N(NUM_CPUS)) u_rr (
        .pending_i (pending_q | req_i),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx),
        .valid_o   (arb_valid)
    );

    assign owner_msg   = bus_msg_clean(msg_arr[owner_q]);
    assign snoop_flush = |(flush_i & ~owner_mask_q);

    // Unpack per-cache buses and build the snoop broadcast; the owner never snoops itself.
    for (genvar gi = 0; gi < NUM_CPUS; gi++) begin : g_cpu
        assign msg_arr[gi]  = msg_i[gi*MSG_W +: MSG_W];
        assign addr_arr[gi] = addr_i[gi*NUM_LINES +: NUM_LINES];
        assign snoop_msg_o[gi*MSG_W +: MSG_W] =
            (state_q == ST_BUS && !owner_mask_q[gi]) ? owner_msg : BUS_IDLE;
    end

    assign gnt_o        = (state_q == ST_GRANT) ? owner_mask_q : '0;
    assign snoop_addr_o = (state_q == ST_BUS) ? addr_arr[owner_q] : '0;
    assign owner_o      = owner_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign wb_o         = (state_q == ST_WB);
    assign txn_done_o   = (state_q == ST_BUS && !snoop_flush) ||
                          (state_q == ST_WB && wb_cnt_q == '0);

    // Next-state logic for the bus FSM, request latch and round-robin pointer.
    always_comb begin
        state_d      = state_q;
        pending_d    = (pending_q & ~gnt_o) | req_i;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        owner_mask_d = owner_mask_q;
        wb_cnt_d     = wb_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d      = ST_GRANT;
                    owner_d      = arb_idx;
                    owner_mask_d = arb_gnt;
                end
            end
            ST_GRANT: begin
                rr_ptr_d = (owner_q == IW'(NUM_CPUS - 1)) ? '0 : owner_q + IW'(1);
                state_d  = ST_BUS;
            end
            ST_BUS: begin
                if (snoop_flush) begin
                    state_d  = ST_WB;
                    wb_cnt_d = CW'(FLUSH_CYCLES - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                if (wb_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    wb_cnt_d = wb_cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            owner_mask_q <= '0;
            wb_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            owner_mask_q <= owner_mask_d;
            wb_cnt_q     <= wb_cnt_d;
        end
    end

    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_i)
        $onehot0(gnt_o));
    a_single_flusher: assert property (@(posedge clk_i) disable iff (!rst_i)
        (state_q == ST_BUS) |-> $onehot0(flush_i & ~owner_mask_q));
    a_no_req_in_grant: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(|(req_i & gnt_o)));

endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Directed-vector bench for msi_bus_arbiter (2 CPUs, 2-bit address, 2 flush cycles).
module tb_msi_bus_arbiter;

    logic       clk_i;
    logic       rst_i;
    logic [1:0] req_i;
    logic [1:0] gnt_o;
    logic [5:0] msg_i;
    logic [3:0] addr_i;
    logic [1:0] flush_i;
    logic [5:0] snoop_msg_o;
    logic [1:0] snoop_addr_o;
    logic [0:0] owner_o;
    logic       busy_o;
    logic       wb_o;
    logic       txn_done_o;

    int n_vec  = 0;
    int n_miss = 0;

    msi_bus_arbiter #(.NUM_CPUS(2), .NUM_LINES(2), .FLUSH_CYCLES(2)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .msg_i        (msg_i),
        .addr_i       (addr_i),
        .flush_i      (flush_i),
        .snoop_msg_o  (snoop_msg_o),
        .snoop_addr_o (snoop_addr_o),
        .owner_o      (owner_o),
        .busy_o       (busy_o),
        .wb_o         (wb_o),
        .txn_done_o   (txn_done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Inputs {msg1,msg0}, {addr1,addr0}; expected packed outputs.
    typedef struct {
        logic [1:0]  req;
        logic [5:0]  msg;
        logic [3:0]  addr;
        logic [1:0]  flush;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[26];

    function automatic logic [13:0] pk(input logic [1:0] g, input logic [5:0] sm,
                                       input logic [1:0] sa, input logic o,
                                       input logic b, input logic w, input logic d);
        return {g, sm, sa, o, b, w, d};
    endfunction

    function automatic vec_t mk(input logic [1:0] req, input logic [5:0] msg,
                                input logic [3:0] addr, input logic [1:0] flush,
                                input logic [13:0] exp);
        vec_t v;
        v.req = req; v.msg = msg; v.addr = addr; v.flush = flush; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] got;
        got = {gnt_o, snoop_msg_o, snoop_addr_o, owner_o, busy_o, wb_o, txn_done_o};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got gnt=%b smsg=%h saddr=%0d own=%0d busy=%b wb=%b done=%b, expected gnt=%b smsg=%h saddr=%0d own=%0d busy=%b wb=%b done=%b",
                     name, got[13:12], got[11:6], got[5:4], got[3], got[2], got[1], got[0],
                     exp[13:12], exp[11:6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
        end else begin
            $display("ok   %s: gnt=%b smsg=%h saddr=%0d own=%0d busy=%b wb=%b done=%b",
                     name, got[13:12], got[11:6], got[5:4], got[3], got[2], got[1], got[0]);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [5:0] msg,
                         input logic [3:0] addr, input logic [1:0] flush);
        req_i = req; msg_i = msg; addr_i = addr; flush_i = flush;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                req    msg    addr  flush      gnt   smsg   sa   own busy wb done
        // simultaneous pair from reset: cpu0 then cpu1
        vecs[0]  = mk(2'b00, 6'h00, 4'h0, 2'b00, pk(2'b00, 6'h00, 2'd0, 0, 0, 0, 0));
        vecs[1]  = mk(2'b11, 6'h00, 4'h0, 2'b00, pk(2'b00, 6'h00, 2'd0, 0, 0, 0, 0));
        vecs[2]  = mk(2'b00, 6'h00, 4'h0, 2'b00, pk(2'b01, 6'h00, 2'd0, 0, 1, 0, 0));
        vecs[3]  = mk(2'b00, 6'h01, 4'h1, 2'b00, pk(2'b00, 6'h08, 2'd1, 0, 1, 0, 1));
        vecs[4]  = mk(2'b00, 6'h00, 4'h0, 2'b00, pk(2'b00, 6'h00, 2'd0, 0, 0, 0, 0));
        vecs[5]  = mk(2'b00, 6'h00, 4'h0, 2'b00, pk(2'b10, 6'h00, 2'd0, 1, 1, 0, 0));
        vecs[6]  = mk(2'b00, 6'h10, 4'h8, 2'b00, pk(2'b00, 6'h02, 2'd2, 1, 1, 0, 1));
        // second simultaneous pair: cpu0 again, cpu1 sends an out-of-range message
        vecs[7]  = mk(2'b11, 6'h00, 4'h0, 2'b00, pk(2'b00, 6'h00, 2'd0, 1, 0, 0, 0));
        vecs[8]  = mk(2'b00, 6'h00, 4'h0, 2'b00, pk(2'b01, 6'h00, 2'd0, 0, 1, 0, 0));
        vecs[9]  = mk(2'b00, 6'h03, 4'h3, 2'b00, pk(2'b00, 6'h18, 2'd3, 0, 1, 0, 1));
        vecs[10] = mk(2'b00, 6'h00, 4'h0, 2'b00, pk(2'b00, 6'h00, 2'd0, 0, 0, 0, 0));
        vecs[11] = mk(2'b00, 6'h00, 4'h0, 2'b00, pk(2'b10, 6'h00, 2'd0, 1, 1, 0, 0));
        vecs[12] = mk(2'b00, 6'h28, 4'h4, 2'b00, pk(2'b00, 6'h00, 2'd1, 1, 1, 0, 1));
        vecs[13] = mk(2'b00, 6'h00, 4'h0, 2'b00, pk(2'b00, 6'h00, 2'd0, 1, 0, 0, 0));
        // cpu0 RDX with cpu1 flushing; cpu1 requests during write-back
        vecs[14] = mk(2'b01, 6'h00, 4'h0, 2'b00, pk(2'b00, 6'h00, 2'd0, 1, 0, 0, 0));
        vecs[15] = mk(2'b00, 6'h00, 4'h0, 2'b00, pk(2'b01, 6'h00, 2'd0, 0, 1, 0, 0));
        vecs[16] = mk(2'b00, 6'h02, 4'h0, 2'b10, pk(2'b00, 6'h10, 2'd0, 0, 1, 0, 0));
        vecs[17] = mk(2'b10, 6'h00, 4'h0, 2'b10, pk(2'b00, 6'h00, 2'd0, 0, 1, 1, 0));
        vecs[18] = mk(2'b00, 6'h00, 4'h0, 2'b00, pk(2'b00, 6'h00, 2'd0, 0, 1, 1, 1));
        vecs[19] = mk(2'b00, 6'h00, 4'h0, 2'b00, pk(2'b00, 6'h00, 2'd0, 0, 0, 0, 0));
        // cpu1 owner with IDLE message and its own flush; cpu0 queues meanwhile
        vecs[20] = mk(2'b01, 6'h00, 4'h0, 2'b00, pk(2'b10, 6'h00, 2'd0, 1, 1, 0, 0));
        vecs[21] = mk(2'b00, 6'h00, 4'hC, 2'b10, pk(2'b00, 6'h00, 2'd3, 1, 1, 0, 1));
        vecs[22] = mk(2'b00, 6'h00, 4'h0, 2'b00, pk(2'b00, 6'h00, 2'd0, 1, 0, 0, 0));
        vecs[23] = mk(2'b00, 6'h00, 4'h0, 2'b00, pk(2'b01, 6'h00, 2'd0, 0, 1, 0, 0));
        vecs[24] = mk(2'b00, 6'h11, 4'h6, 2'b00, pk(2'b00, 6'h08, 2'd2, 0, 1, 0, 1));
        vecs[25] = mk(2'b00, 6'h00, 4'h0, 2'b00, pk(2'b00, 6'h00, 2'd0, 0, 0, 0, 0));

        rst_i = 1'b0;
        drive(2'b00, 6'h00, 4'h0, 2'b00);
        repeat (2) @(negedge clk_i);
        #1 check("in_reset", pk(2'b00, 6'h00, 2'd0, 0, 0, 0, 0));
        rst_i = 1'b1;

        for (int i = 0; i < 26; i++) begin
            @(negedge clk_i);
            drive(vecs[i].req, vecs[i].msg, vecs[i].addr, vecs[i].flush);
            #1 check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset asserted in the middle of a BUS cycle with cpu1 still pending.
        @(negedge clk_i);
        drive(2'b01, 6'h00, 4'h0, 2'b00);
        #1 check("rst_seq_idle", pk(2'b00, 6'h00, 2'd0, 0, 0, 0, 0));
        @(negedge clk_i);
        drive(2'b10, 6'h00, 4'h0, 2'b00);
        #1 check("rst_seq_grant", pk(2'b01, 6'h00, 2'd0, 0, 1, 0, 0));
        @(negedge clk_i);
        drive(2'b00, 6'h01, 4'h1, 2'b00);
        #1 check("rst_seq_bus", pk(2'b00, 6'h08, 2'd1, 0, 1, 0, 1));
        #1 rst_i = 1'b0;
        #1 check("rst_seq_async", pk(2'b00, 6'h00, 2'd0, 0, 0, 0, 0));
        drive(2'b00, 6'h00, 4'h0, 2'b00);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            #1 check($sformatf("post_rst%0d", i), pk(2'b00, 6'h00, 2'd0, 0, 0, 0, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
